// File: rtl/hack_pkg.sv
// Shared definitions for the Hack memory blocks.
package hack_pkg;

    // Default Hack data word width.
    localparam int HACK_WORD_W = 16;

    // Clear sequencer states: CLEAR sweeps the array to zero, IDLE serves user traffic.
    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } ram_state_t;

endpackage

// File: rtl/ram_clear_fsm.sv
// Clear sequencer for ram_n: owns state, sweep pointer and busy, and steers the
// array write port between the sweep path and the user path.
//
// Handshake: there is no valid/ready pair. load and clear are single-cycle
// requests sampled at posedge while busy=0; while busy=1 every request is
// dropped and the sweep is never restarted except by reset.
module ram_clear_fsm
    import hack_pkg::*;
#(
    parameter int WIDTH  = HACK_WORD_W,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] address,
    input  logic [WIDTH-1:0]  in,
    input  logic              clear,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [WIDTH-1:0]  wdata,
    output logic              busy,
    output ram_state_t        state
);

    // Last word of the sweep; the pointer wraps to zero naturally after it.
    localparam logic [ADDR_W-1:0] PTR_LAST = '1;

    logic [ADDR_W-1:0] ptr;

    // Sequencer state and sweep pointer; reset (re)starts a full sweep from word 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= CLEAR;
            ptr   <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    ptr <= ptr + ADDR_W'(1);
                    if (ptr == PTR_LAST) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (clear) begin
                        state <= CLEAR;
                        ptr   <= '0;
                    end
                end
                default: begin
                    state <= CLEAR;
                    ptr   <= '0;
                end
            endcase
        end
    end

    // Write-port mux: the sweep owns the array while busy, the user otherwise.
    always_comb begin
        busy  = 1'b0;
        we    = load;
        waddr = address;
        wdata = in;
        if (state == CLEAR) begin
            busy  = 1'b1;
            we    = 1'b1;
            waddr = ptr;
            wdata = '0;
        end
    end

endmodule

// File: rtl/ram_n.sv
// Parametrised word-addressed Hack RAM (WIDTH x 2**ADDR_W) with a self-clearing
// sequencer that zeroes the array after reset or on a clear request.
// Optional build macro RAM_READ_REG_EN: registered read (1-cycle latency,
// read-before-write); otherwise the read is combinational.
module ram_n
    import hack_pkg::*;
#(
    parameter int WIDTH  = HACK_WORD_W,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] address,
    input  logic [WIDTH-1:0]  in,
    input  logic              clear,
    output logic [WIDTH-1:0]  out,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [WIDTH-1:0]  wdata;
    ram_state_t        fsm_state;

    ram_clear_fsm #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_clear_fsm (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .address (address),
        .in      (in),
        .clear   (clear),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .busy    (busy),
        .state   (fsm_state)
    );

    // Storage array; contents are deliberately not reset, the sweep zeroes them.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

`ifdef RAM_READ_REG_EN
    // Registered read: samples the old word on a same-edge write, and is forced
    // to zero on any edge that enters or stays in the sweep.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out <= '0;
        end else if (fsm_state == IDLE && !clear) begin
            out <= mem[address];
        end else begin
            out <= '0;
        end
    end
`else
    // Combinational read with zero latency; masked to zero while sweeping.
    always_comb begin
        out = '0;
        if (fsm_state == IDLE) begin
            out = mem[address];
        end
    end
`endif

endmodule
